// File: rtl/usb_rx_pkg.sv
// Shared constants and state type for the USB receive unstuff/deserialize path.
package usb_rx_pkg;
  localparam int STUFF_LIMIT = 6;
  localparam int BYTE_W      = 8;
  localparam int CNT_W       = $clog2(BYTE_W);
  localparam int ONES_W      = $clog2(STUFF_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERROR
  } rx_state_t;
endpackage

// File: rtl/rx_unstuff_deserializer_if.sv
// Bit-stream input and byte/error output bundle between the NRZI decoder, this stage and the PID layer.
interface rx_unstuff_deserializer_if;
  logic       rx_active;
  logic       bit_valid;
  logic       decoded_bit;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       stuff_err;
  logic       align_err;

  modport master (
    output rx_active, bit_valid, decoded_bit,
    input  byte_out, byte_valid, stuff_err, align_err
  );

  modport slave (
    input  rx_active, bit_valid, decoded_bit,
    output byte_out, byte_valid, stuff_err, align_err
  );
endinterface

// File: rtl/rx_unstuff_deserializer_bit_unstuffer.sv
// Tracks consecutive ones and decides, per valid bit, whether it is data, a stuffed zero, or a violation.
module bit_unstuffer
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic nRST,
  input  logic i_clear,
  input  logic i_bit_valid,
  input  logic i_bit,
  output logic o_accept_bit,
  output logic o_data_bit,
  output logic o_stuff_violation
);

  logic [ONES_W-1:0] r_ones;
  logic              w_at_limit;

  assign w_at_limit        = (r_ones == ONES_W'(STUFF_LIMIT));
  assign o_accept_bit      = i_bit_valid && !w_at_limit;
  assign o_data_bit        = i_bit;
  assign o_stuff_violation = i_bit_valid && w_at_limit && i_bit;

  // The count is deliberately not reset at byte boundaries: stuffing spans bytes.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_ones <= '0;
    end else if (i_clear) begin
      r_ones <= '0;
    end else if (i_bit_valid) begin
      if (w_at_limit || !i_bit) r_ones <= '0;
      else                      r_ones <= r_ones + ONES_W'(1);
    end
  end

endmodule

// File: rtl/rx_unstuff_deserializer.sv
// Removes USB stuffed bits and assembles the surviving bits LSB-first into byte strobes.
module rx_unstuff_deserializer
  import usb_rx_pkg::*;
(
  input  logic                     clk,
  input  logic                     nRST,
  rx_unstuff_deserializer_if.slave bus
);

  rx_state_t          r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [BYTE_W-2:0]  r_shift;
  logic [BYTE_W-1:0]  r_byte;
  logic               r_byte_valid;
  logic               r_stuff_err;
  logic               r_align_err;

  logic w_live;
  logic w_accept;
  logic w_data;
  logic w_violation;

  // A bit arriving with the rising edge of rx_active is already processed as ACTIVE.
  assign w_live = bus.rx_active && (r_state != ERROR);

  bit_unstuffer u_unstuffer (
    .clk               (clk),
    .nRST              (nRST),
    .i_clear           (!w_live),
    .i_bit_valid       (bus.bit_valid && w_live),
    .i_bit             (bus.decoded_bit),
    .o_accept_bit      (w_accept),
    .o_data_bit        (w_data),
    .o_stuff_violation (w_violation)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_align_err  <= 1'b0;
      case (r_state)
        IDLE, ACTIVE: begin
          if (!bus.rx_active) begin
            if (r_state == ACTIVE && r_bit_cnt != '0) r_align_err <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= IDLE;
          end else begin
            r_state <= ACTIVE;
            if (w_violation) begin
              r_stuff_err <= 1'b1;
              r_bit_cnt   <= '0;
              r_state     <= ERROR;
            end else if (w_accept) begin
              if (r_bit_cnt == CNT_W'(BYTE_W - 1)) begin
                r_byte       <= {w_data, r_shift};
                r_byte_valid <= 1'b1;
                r_bit_cnt    <= '0;
              end else begin
                r_shift[r_bit_cnt] <= w_data;
                r_bit_cnt          <= r_bit_cnt + CNT_W'(1);
              end
            end
          end
        end
        ERROR: begin
          r_bit_cnt <= '0;
          if (!bus.rx_active) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.byte_out   = r_byte;
  assign bus.byte_valid = r_byte_valid;
  assign bus.stuff_err  = r_stuff_err;
  assign bus.align_err  = r_align_err;

endmodule

// File: tb/tb_rx_unstuff_deserializer.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor pops and compares them.
module tb_rx_unstuff_deserializer;

  localparam int K_BYTE  = 0;
  localparam int K_STUFF = 1;
  localparam int K_ALIGN = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic nRST;
  always #5 clk = ~clk;

  rx_unstuff_deserializer_if bus ();

  rx_unstuff_deserializer dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor: every strobe the DUT raises must match the head of the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   kind;
    if (nRST === 1'b1 && (bus.byte_valid || bus.stuff_err || bus.align_err)) begin
      check("one_strobe", $countones({bus.byte_valid, bus.stuff_err, bus.align_err}), 1);
      kind = bus.byte_valid ? K_BYTE : (bus.stuff_err ? K_STUFF : K_ALIGN);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got kind %0d, expected none at %0t", kind, $time);
      end else begin
        e = q.pop_front();
        check("strobe_kind", kind, e.kind);
        if (kind == K_BYTE) check("byte_out", int'(bus.byte_out), int'(e.data));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx_active   = 1'b1;
      bus.bit_valid   = 1'b1;
      bus.decoded_bit = bits[i];
      tick();
    end
    bus.bit_valid   = 1'b0;
    bus.decoded_bit = 1'b0;
  endtask

  task automatic end_pkt;
    bus.rx_active = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_byte_out"},   int'(bus.byte_out), 0);
    check({tag, "_byte_valid"}, int'(bus.byte_valid), 0);
    check({tag, "_stuff_err"},  int'(bus.stuff_err), 0);
    check({tag, "_align_err"},  int'(bus.align_err), 0);
  endtask

  initial begin
    nRST            = 1'b0;
    bus.rx_active   = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.decoded_bit = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 nRST = 1'b1;
    repeat (2) tick();

    // Plain byte 1,0,1,0,0,1,0,1 -> A5
    expect_ev(K_BYTE, 8'hA5);
    send_bits(32'hA5, 8);
    end_pkt();
    check("byte_out_hold", int'(bus.byte_out), 8'hA5);

    // Six ones, stuffed zero, two ones -> FF
    expect_ev(K_BYTE, 8'hFF);
    send_bits(32'h1BF, 9);
    end_pkt();

    // Stuffing across a byte boundary: F0 then 3F
    expect_ev(K_BYTE, 8'hF0);
    send_bits(32'hF0, 8);
    expect_ev(K_BYTE, 8'h3F);
    send_bits(32'h07B, 9);
    end_pkt();

    // Seven ones -> stuff error, further bits ignored until rx_active drops
    expect_ev(K_STUFF, 8'h00);
    send_bits(32'h7F, 7);
    send_bits(32'h00, 8);
    send_bits(32'hFF, 8);
    end_pkt();
    expect_ev(K_BYTE, 8'h3C);
    send_bits(32'h3C, 8);
    end_pkt();

    // Five bits then rx_active low with a simultaneous bit -> align error only
    send_bits(32'h15, 5);
    expect_ev(K_ALIGN, 8'h00);
    bus.rx_active   = 1'b0;
    bus.bit_valid   = 1'b1;
    bus.decoded_bit = 1'b1;
    tick();
    end_pkt();

    // Empty packet: no strobes at all
    bus.rx_active = 1'b1;
    repeat (3) tick();
    end_pkt();

    // Asynchronous reset mid-byte, then a clean byte
    send_bits(32'h0F, 4);
    #2 nRST = 1'b0;
    bus.rx_active = 1'b0;
    @(negedge clk);
    check_outputs_zero("async_rst");
    @(posedge clk);
    #1 nRST = 1'b1;
    tick();
    expect_ev(K_BYTE, 8'h96);
    send_bits(32'h96, 8);
    end_pkt();

    repeat (5) tick();
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_unstuff_deserializer.md
# rx_unstuff_deserializer

Receive-path stage that takes the NRZI-decoded serial bit stream and removes USB stuffed bits, flagging any stuff violation. It then assembles the surviving bits LSB-first into bytes, emitting one-cycle byte strobes. It sits directly downstream of the NRZI decoder and feeds the packet/PID layer.

## Interface
- No parameters; constants come from `usb_rx_pkg`.
- `clk`  in  1  system clock
- `nRST`  in  1  asynchronous active-low reset
- `rx_active`  in  1  high while a packet is being received; low = idle/EOP
- `bit_valid`  in  1  qualifies `decoded_bit` for this cycle (one bit period strobe)
- `decoded_bit`  in  1  NRZI-decoded bit from the decoder
- `byte_out`  out  8  assembled byte, LSB = first received bit
- `byte_valid`  out  1  one-cycle strobe, `byte_out` valid
- `stuff_err`  out  1  one-cycle strobe on a seven-ones violation
- `align_err`  out  1  one-cycle strobe when a packet ends mid-byte

## Operation
- States: IDLE, ACTIVE, ERROR.
- IDLE:
  - ones count = 0, bit count = 0.
  - `rx_active` high moves to ACTIVE.
  - Bits presented in the same cycle as `rx_active` rises are processed as ACTIVE.
- ACTIVE, on each `bit_valid`:
  - ones count < 6:
    - Accept the bit.
    - Shift into the byte register at position bit count; increment bit count.
    - A 1 increments ones count; a 0 clears it.
  - ones count == 6 and bit == 0:
    - Stuffed bit. Drop it: no shift, no bit count change.
    - Ones count = 0.
  - ones count == 6 and bit == 1:
    - Pulse `stuff_err`.
    - Discard the partial byte; bit count = 0.
    - Go to ERROR.
  - Accepted bit that makes bit count reach 8:
    - Load `byte_out`, pulse `byte_valid`, bit count = 0.
    - Ones count is not cleared; stuffing spans byte boundaries.
- `rx_active` low while in ACTIVE:
  - bit count != 0: pulse `align_err` and discard the partial byte.
  - Return to IDLE.
  - `rx_active` low overrides a simultaneous `bit_valid`; that bit is ignored.
- ERROR:
  - Ignore all bits.
  - `rx_active` low returns to IDLE with no `align_err`.
- `byte_out` holds its last value between strobes.

## Timing
- Reset values: `byte_out` = 8'h00, `byte_valid` = 0, `stuff_err` = 0, `align_err` = 0, state = IDLE, both counters = 0.
- All outputs are registered.
- An 8th accepted bit sampled at edge k gives `byte_valid` high for exactly the cycle following edge k, with `byte_out` valid in that same cycle.
- `stuff_err` and `align_err` follow the same one-cycle latency relative to the triggering edge.
- Back-to-back `bit_valid` every cycle is supported: sustained one byte per 8 accepted bits, no bubbles.
- `nRST` asserted mid-byte clears everything immediately (asynchronously); no strobes are generated.
- At most one of `byte_valid` / `stuff_err` / `align_err` is high in any cycle.

## Structure
- `usb_rx_pkg` holds:
  - `STUFF_LIMIT` = 6
  - `BYTE_W` = 8
  - the state enum `rx_state_t` {IDLE, ACTIVE, ERROR}
- One natural sub-module, `bit_unstuffer`:
  - Contains the ones counter and the drop/violation decision.
  - Outputs `accept_bit`, `data_bit`, `stuff_violation`.
- The top level holds the FSM, bit counter, shift register and output registers.

## Test plan
- rx_active high, bits 1,0,1,0,0,1,0,1 (one per `bit_valid`) -> `byte_valid` one cycle, `byte_out` = 8'hA5, no errors.
- Bits 1,1,1,1,1,1,0(stuffed),1,1 -> single `byte_valid`, `byte_out` = 8'hFF; the stuffed 0 is not counted.
- Cross-boundary stuffing: byte F0 (0,0,0,0,1,1,1,1), then 1,1,0(stuffed),1,1,1,1,0,0 -> bytes 8'hF0 then 8'h3F.
- Seven consecutive 1s -> `stuff_err` pulse on the cycle after the 7th bit; further bits produce no `byte_valid` until rx_active toggles low/high; the next packet decodes normally.
- 5 bits then rx_active low -> `align_err` one cycle, no `byte_valid`; rx_active low with bit count 0 -> no `align_err`.
- `nRST` pulsed after 4 bits -> all outputs 0 and no strobe; the next 8 bits produce a correct byte.
